// File: rtl/ram_burst_init.sv
// Burst sequencer that turns one address/length command into a run of
// single-word RAM writes or reads, returning read data one cycle later.
module ram_burst_init #(
    parameter int CAddrLen = 13,
    parameter int CDataLen = 128,
    parameter int CLenLen  = 8
) (
    input  logic                AClkH,
    input  logic                AResetHN,
    input  logic                AClkHEn,
    input  logic [CAddrLen-1:0] ACmdAddr,
    input  logic [CLenLen-1:0]  ACmdLen,
    input  logic                ACmdWr,
    input  logic                ACmdVld,
    output logic                ACmdRdy,
    input  logic [CDataLen-1:0] AWrData,
    input  logic                AWrVld,
    output logic                AWrRdy,
    output logic [CDataLen-1:0] ARdData,
    output logic                ARdVld,
    output logic [CAddrLen-1:0] ARamAddr,
    output logic [CDataLen-1:0] ARamMosi,
    input  logic [CDataLen-1:0] ARamMiso,
    output logic                ARamWrEn,
    output logic                ARamRdEn,
    output logic                ABusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CAddrLen-1:0] r_addr;
    logic [CLenLen-1:0]  r_cnt;
    logic                r_rd_pend;

    logic w_cmd_rdy;
    logic w_wr_beat;
    logic w_rd_beat;
    logic w_last;

    // Holding off new commands while read data is in flight keeps a
    // following write from overlapping the final returned word.
    assign w_cmd_rdy = (r_state == IDLE) && !r_rd_pend;
    assign w_wr_beat = (r_state == WR) && AWrVld && AClkHEn;
    assign w_rd_beat = (r_state == RD) && AClkHEn;
    assign w_last    = (r_cnt == '0);

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_rd_pend <= 1'b0;
        end else if (AClkHEn) begin
            r_rd_pend <= w_rd_beat;
            if (r_state == IDLE) begin
                if (ACmdVld && w_cmd_rdy) begin
                    r_addr  <= ACmdAddr;
                    r_cnt   <= ACmdLen;
                    r_state <= ACmdWr ? WR : RD;
                end
            end else if (w_wr_beat || w_rd_beat) begin
                r_addr <= r_addr + CAddrLen'(1);
                r_cnt  <= r_cnt - CLenLen'(1);
                if (w_last) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign ACmdRdy  = w_cmd_rdy;
    assign AWrRdy   = (r_state == WR);
    assign ARamWrEn = w_wr_beat;
    assign ARamRdEn = w_rd_beat;
    assign ARamAddr = r_addr;
    assign ARamMosi = w_wr_beat ? AWrData : '0;
    assign ARdVld   = r_rd_pend;
    assign ARdData  = r_rd_pend ? ARamMiso : '0;
    assign ABusy    = (r_state != IDLE) || r_rd_pend;

endmodule

// File: tb/tb_ram_burst_init.sv
// Directed bench for ram_burst_init with a one-cycle-latency RAM model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ram_burst_init;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [12:0]  cmd_addr = '0;
    logic [7:0]   cmd_len = '0;
    logic         cmd_wr = 1'b0;
    logic         cmd_vld = 1'b0;
    logic         cmd_rdy;
    logic [127:0] wr_data = '0;
    logic         wr_vld = 1'b0;
    logic         wr_rdy;
    logic [127:0] rd_data;
    logic         rd_vld;
    logic [12:0]  ram_addr;
    logic [127:0] ram_mosi;
    logic [127:0] ram_miso = '0;
    logic         ram_wr;
    logic         ram_rd;
    logic         busy;

    int n_pass = 0;
    int n_chk = 0;

    logic [127:0] D [4];
    logic [127:0] mem [8192];

    always #5 clk = ~clk;

    ram_burst_init dut (
        .AClkH    (clk),
        .AResetHN (rst_n),
        .AClkHEn  (en),
        .ACmdAddr (cmd_addr),
        .ACmdLen  (cmd_len),
        .ACmdWr   (cmd_wr),
        .ACmdVld  (cmd_vld),
        .ACmdRdy  (cmd_rdy),
        .AWrData  (wr_data),
        .AWrVld   (wr_vld),
        .AWrRdy   (wr_rdy),
        .ARdData  (rd_data),
        .ARdVld   (rd_vld),
        .ARamAddr (ram_addr),
        .ARamMosi (ram_mosi),
        .ARamMiso (ram_miso),
        .ARamWrEn (ram_wr),
        .ARamRdEn (ram_rd),
        .ABusy    (busy)
    );

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_mosi;
        if (ram_rd) ram_miso <= mem[ram_addr];
    end

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b1;
        #1;
        n_chk++;
        if ({cmd_rdy, busy, ram_wr, ram_rd, rd_vld, wr_rdy} !== 6'b100000)
            $display("FAIL rst_flags got=%b exp=100000",
                     {cmd_rdy, busy, ram_wr, ram_rd, rd_vld, wr_rdy});
        else n_pass++;
        n_chk++;
        if (rd_data !== '0 || ram_mosi !== '0 || ram_addr !== '0)
            $display("FAIL rst_buses got=%h/%h/%h exp=0",
                     rd_data, ram_mosi, ram_addr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (cmd_rdy !== 1'b1)
            $display("FAIL rst_release_rdy got=%b exp=1", cmd_rdy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write;
        cmd_addr = 13'h010; cmd_len = 8'd3; cmd_wr = 1'b1; cmd_vld = 1'b1;
        #1;
        n_chk++;
        if (cmd_rdy !== 1'b1) $display("FAIL wr_accept got=%b exp=1", cmd_rdy);
        else n_pass++;
        @(negedge clk);
        cmd_vld = 1'b0;
        wr_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = D[i];
            #1;
            n_chk++;
            if ({ram_wr, wr_rdy} !== 2'b11 || ram_addr !== 13'(13'h010 + i)
                || ram_mosi !== D[i])
                $display("FAIL wr_beat%0d got=%b%b @%h %h exp=11 @%h %h",
                         i, ram_wr, wr_rdy, ram_addr, ram_mosi,
                         13'(13'h010 + i), D[i]);
            else n_pass++;
            @(negedge clk);
        end
        wr_vld = 1'b0;
        #1;
        n_chk++;
        if ({cmd_rdy, busy, ram_wr} !== 3'b100)
            $display("FAIL wr_done got=%b exp=100", {cmd_rdy, busy, ram_wr});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_readback;
        logic [127:0] exp_d;
        logic exp_rd;
        logic exp_vld;
        cmd_addr = 13'h010; cmd_len = 8'd3; cmd_wr = 1'b0; cmd_vld = 1'b1;
        #1;
        @(negedge clk);
        cmd_vld = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            exp_rd = (i <= 4);
            exp_vld = (i >= 2 && i <= 5);
            exp_d = '0;
            if (exp_vld) exp_d = D[i-2];
            #1;
            n_chk++;
            if (ram_rd !== exp_rd || (exp_rd && ram_addr !== 13'(13'h00F + i)))
                $display("FAIL rd_issue%0d got=%b @%h exp=%b @%h",
                         i, ram_rd, ram_addr, exp_rd, 13'(13'h00F + i));
            else n_pass++;
            n_chk++;
            if (rd_vld !== exp_vld || rd_data !== exp_d)
                $display("FAIL rd_data%0d got=%b %h exp=%b %h",
                         i, rd_vld, rd_data, exp_vld, exp_d);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap;
        logic [12:0] exp_a [4];
        exp_a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        cmd_addr = 13'h1FFE; cmd_len = 8'd3; cmd_wr = 1'b0; cmd_vld = 1'b1;
        #1;
        @(negedge clk);
        cmd_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (ram_rd !== 1'b1 || ram_addr !== exp_a[i])
                $display("FAIL wrap%0d got=%b @%h exp=1 @%h",
                         i, ram_rd, ram_addr, exp_a[i]);
            else n_pass++;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL wrap_idle got=%b exp=0", busy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall;
        int nw;
        cmd_addr = 13'h100; cmd_len = 8'd3; cmd_wr = 1'b1; cmd_vld = 1'b1;
        #1;
        @(negedge clk);
        cmd_vld = 1'b0;
        nw = 0;
        for (int c = 0; c < 40 && nw < 4; c++) begin
            en = (c % 2 == 0);
            wr_vld = (c % 3 != 1);
            wr_data = 128'hA0 + 128'(nw);
            #1;
            if (!en) begin
                n_chk++;
                if (ram_wr !== 1'b0 || ram_rd !== 1'b0)
                    $display("FAIL stall_en0 c=%0d got=%b%b exp=00",
                             c, ram_wr, ram_rd);
                else n_pass++;
            end
            if (ram_wr) begin
                n_chk++;
                if (ram_addr !== 13'(13'h100 + nw)
                    || ram_mosi !== 128'hA0 + 128'(nw))
                    $display("FAIL stall_beat%0d got=@%h %h exp=@%h %h",
                             nw, ram_addr, ram_mosi,
                             13'(13'h100 + nw), 128'hA0 + 128'(nw));
                else n_pass++;
                nw++;
            end
            @(negedge clk);
        end
        n_chk++;
        if (nw !== 4) $display("FAIL stall_count got=%0d exp=4", nw);
        else n_pass++;
        en = 1'b1;
        wr_vld = 1'b1;
        #1;
        n_chk++;
        if ({ram_wr, cmd_rdy, wr_rdy} !== 3'b010)
            $display("FAIL stall_after got=%b exp=010", {ram_wr, cmd_rdy, wr_rdy});
        else n_pass++;
        @(negedge clk);
        wr_vld = 1'b0;
    endtask

    task automatic test_max_len;
        int cnt;
        cmd_addr = 13'h000; cmd_len = 8'hFF; cmd_wr = 1'b0; cmd_vld = 1'b1;
        #1;
        @(negedge clk);
        cmd_vld = 1'b0;
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (ram_rd) cnt++;
            if (!busy) break;
            @(negedge clk);
        end
        n_chk++;
        if (cnt !== 256 || ram_addr !== 13'h100 || busy !== 1'b0)
            $display("FAIL maxlen got=%0d @%h busy=%b exp=256 @100 busy=0",
                     cnt, ram_addr, busy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        cmd_addr = 13'h200; cmd_len = 8'd7; cmd_wr = 1'b0; cmd_vld = 1'b1;
        #1;
        @(negedge clk);
        cmd_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++;
            if (ram_rd !== 1'b1 || ram_addr !== 13'(13'h200 + i))
                $display("FAIL rstmid_issue%0d got=%b @%h exp=1 @%h",
                         i, ram_rd, ram_addr, 13'(13'h200 + i));
            else n_pass++;
            @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ram_rd, rd_vld, busy, cmd_rdy} !== 4'b0001 || ram_addr !== '0)
            $display("FAIL rstmid_async got=%b @%h exp=0001 @0",
                     {ram_rd, rd_vld, busy, cmd_rdy}, ram_addr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({ram_rd, rd_vld} !== 2'b00)
                $display("FAIL rstmid_quiet%0d got=%b exp=00", i, {ram_rd, rd_vld});
            else n_pass++;
            @(negedge clk);
        end
        cmd_addr = 13'h300; cmd_len = 8'd0; cmd_wr = 1'b1; cmd_vld = 1'b1;
        #1;
        n_chk++;
        if (cmd_rdy !== 1'b1) $display("FAIL rstmid_rdy got=%b exp=1", cmd_rdy);
        else n_pass++;
        @(negedge clk);
        cmd_vld = 1'b0;
        wr_vld = 1'b1;
        wr_data = D[3];
        #1;
        n_chk++;
        if (ram_wr !== 1'b1 || ram_addr !== 13'h300 || ram_mosi !== D[3])
            $display("FAIL rstmid_wr got=%b @%h %h exp=1 @300 %h",
                     ram_wr, ram_addr, ram_mosi, D[3]);
        else n_pass++;
        @(negedge clk);
        wr_vld = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rstmid_idle got=%b exp=0", busy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [3:0] rdy_exp;
        rdy_exp = 4'b1000;
        cmd_addr = 13'h010; cmd_len = 8'd1; cmd_wr = 1'b0; cmd_vld = 1'b1;
        #1;
        @(negedge clk);
        cmd_addr = 13'h400; cmd_len = 8'd0; cmd_wr = 1'b1;
        wr_vld = 1'b1;
        wr_data = D[2];
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_chk++;
            if (cmd_rdy !== rdy_exp[i-1] || wr_rdy !== 1'b0)
                $display("FAIL b2b_rdy%0d got=%b%b exp=%b0",
                         i, cmd_rdy, wr_rdy, rdy_exp[i-1]);
            else n_pass++;
            n_chk++;
            if ((ram_wr & rd_vld) !== 1'b0)
                $display("FAIL b2b_collide%0d got=1 exp=0", i);
            else n_pass++;
            @(negedge clk);
        end
        cmd_vld = 1'b0;
        #1;
        n_chk++;
        if (ram_wr !== 1'b1 || ram_addr !== 13'h400 || rd_vld !== 1'b0)
            $display("FAIL b2b_wr got=%b @%h vld=%b exp=1 @400 vld=0",
                     ram_wr, ram_addr, rd_vld);
        else n_pass++;
        @(negedge clk);
        wr_vld = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", busy);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        D[0] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        D[1] = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
        D[2] = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;
        D[3] = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_3C3C_C3C3;
        @(negedge clk);
        test_reset();
        test_write();
        test_readback();
        test_wrap();
        test_stall();
        test_max_len();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
